// File: rtl/bin8_bcd_display.sv
// bin8_bcd_display: sequential double-dabble conversion of an 8-bit count to three active-low 7-segment digits
module bin8_bcd_display #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       Clock,
    input  logic       Clearn,
    input  logic [7:0] Q_in,
    output logic [0:6] HEX2,
    output logic [0:6] HEX1,
    output logic [0:6] HEX0,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t      state;
    logic [7:0]  last_bin;
    logic [19:0] shreg;
    logic [19:0] adj;
    logic [2:0]  cnt;
    logic [3:0]  dig_h, dig_t, dig_u;
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction
    function automatic logic [0:6] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    endfunction
    assign adj  = {add3(shreg[19:16]), add3(shreg[15:12]), add3(shreg[11:8]), shreg[7:0]};
    assign busy = (state != IDLE);
    always_ff @(posedge Clock or negedge Clearn) begin
        if (!Clearn) begin
            state    <= IDLE;
            last_bin <= '0;
            shreg    <= '0;
            cnt      <= '0;
            dig_h    <= '0;
            dig_t    <= '0;
            dig_u    <= '0;
        end else begin
            case (state)
                IDLE: if (Q_in != last_bin) begin
                    last_bin <= Q_in;
                    shreg    <= {12'b0, Q_in};
                    cnt      <= '0;
                    state    <= CONV;
                end
                CONV: begin
                    shreg <= adj << 1;
                    cnt   <= cnt + 3'd1;
                    state <= (cnt == 3'd7) ? DONE : CONV;
                end
                default: begin
                    dig_h <= shreg[19:16];
                    dig_t <= shreg[15:12];
                    dig_u <= shreg[11:8];
                    state <= IDLE;
                end
            endcase
        end
    end
    // tens stays visible whenever hundreds is nonzero, so "100" keeps its inner zero
    assign HEX2 = (BLANK_LEADING && dig_h == 4'd0) ? 7'b1111111 : seg(dig_h);
    assign HEX1 = (BLANK_LEADING && dig_h == 4'd0 && dig_t == 4'd0) ? 7'b1111111 : seg(dig_t);
    assign HEX0 = seg(dig_u);
endmodule

// File: tb/tb_bin8_bcd_display.sv
// tb_bin8_bcd_display: directed and random checks of both blanking variants against a decimal model
module tb_bin8_bcd_display;
    logic       Clock = 1'b0;
    logic       Clearn = 1'b0;
    logic [7:0] Q_in = 8'd0;
    logic [0:6] h2b, h1b, h0b, h2n, h1n, h0n;
    logic       busy_b, busy_n;
    int         checks = 0;
    int         errors = 0;
    int         cur = 0;
    logic [6:0] segt [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    bin8_bcd_display #(.BLANK_LEADING(1'b1)) u_b (
        .Clock(Clock), .Clearn(Clearn), .Q_in(Q_in),
        .HEX2(h2b), .HEX1(h1b), .HEX0(h0b), .busy(busy_b)
    );
    bin8_bcd_display #(.BLANK_LEADING(1'b0)) u_n (
        .Clock(Clock), .Clearn(Clearn), .Q_in(Q_in),
        .HEX2(h2n), .HEX1(h1n), .HEX0(h0n), .busy(busy_n)
    );

    always #5 Clock = ~Clock;

    function automatic logic [20:0] disp(input int v, input bit blank);
        int h = v / 100;
        int t = (v / 10) % 10;
        int u = v % 10;
        return {(blank && h == 0) ? 7'h7f : segt[h], (blank && v < 10) ? 7'h7f : segt[t], segt[u]};
    endfunction

    task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit exp_busy, input int val);
        chk({tag, "_blank"}, {busy_b, h2b, h1b, h0b}, {exp_busy, disp(val, 1'b1)});
        chk({tag, "_noblank"}, {busy_n, h2n, h1n, h0n}, {exp_busy, disp(val, 1'b0)});
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // capture edge, eight shift edges with the old display held, then the new digits
    task automatic conv(input int v, input int chg_at = -1, input int nv = 0);
        Q_in = 8'(v);
        step();
        chk_all("capture", 1'b1, cur);
        for (int i = 1; i <= 8; i++) begin
            if (i == chg_at) Q_in = 8'(nv);
            step();
            chk_all("shifting", 1'b1, cur);
        end
        step();
        cur = v;
        chk_all("done", 1'b0, cur);
    endtask

    initial begin
        #1;
        chk_all("reset", 1'b0, 0);
        step();
        step();
        Clearn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all("idle_zero", 1'b0, 0);
        end
        conv(255);
        conv(100);
        conv(9);
        conv(12, 3, 200);
        conv(200);
        Q_in = 8'd173;
        step();
        chk_all("r_capture", 1'b1, cur);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_all("r_shifting", 1'b1, cur);
        end
        #1 Clearn = 1'b0;
        #1;
        cur = 0;
        chk_all("mid_reset", 1'b0, 0);
        #1 Clearn = 1'b1;
        conv(173);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("same_value", 1'b0, cur);
        end
        for (int i = 0; i < 20; i++) begin
            int v = int'($urandom_range(0, 255));
            if (v == cur) v = (v + 1) % 256;
            conv(v);
        end
        if (cur != 255) conv(255);
        conv(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
